// File: rtl/pll_sup_pkg.sv
// pll_sup_pkg: shared types and helpers for the PLL lock supervisor.
//   pll_sup_state_e  per-channel supervisor FSM states
//   pll_cfg_t        {ok, icpsel, lpfres} loop settings for one factor
//   pll_cfg_lookup() multiplication factor -> loop settings (ok=0 if unsupported)
//   cnt_w()          width of a counter that must hold 0..max_val
//   max3()           largest of three ints, for shared counter sizing
package pll_sup_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RESET,
    ST_WAIT_LOCK,
    ST_EN_WAIT,
    ST_RUN,
    ST_LOST,
    ST_FAIL
  } pll_sup_state_e;

  typedef struct packed {
    logic       ok;
    logic [5:0] icpsel;
    logic [2:0] lpfres;
  } pll_cfg_t;

  // Supported feedback multiplication factors; anything else leaves ok=0.
  function automatic pll_cfg_t pll_cfg_lookup(input int multi_fac);
    pll_cfg_t cfg;
    case (multi_fac)
      8:       cfg = '{1'b1, 6'h0A, 3'd5};
      12:      cfg = '{1'b1, 6'h0F, 3'd4};
      16:      cfg = '{1'b1, 6'h14, 3'd4};
      24:      cfg = '{1'b1, 6'h1C, 3'd3};
      32:      cfg = '{1'b1, 6'h24, 3'd2};
      48:      cfg = '{1'b1, 6'h30, 3'd1};
      default: cfg = '{1'b0, 6'h00, 3'd0};
    endcase
    return cfg;
  endfunction

  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/pll_sup_chan.sv
// pll_sup_chan: supervisor for one PLL: lock synchroniser, reset/lock/enable
// sequencing, timeout with bounded retry and filtered loss-of-lock recovery.
//   init_clk, reset  supervisor clock, synchronous active-high reset
//   pll_lock         raw asynchronous PLL lock
//   restart          single-cycle restart request
//   enable           permission to leave IDLE (upstream locked in a cascade)
//   kill             an upstream channel is leaving lock: fall back to IDLE
//   pll_rst, enclk, lock, fail  registered channel outputs
//   drop             combinational: this channel leaves EN_WAIT/RUN this cycle
module pll_sup_chan
  import pll_sup_pkg::*;
#(
  parameter int RST_CYC          = 50,
  parameter int LOCK_TIMEOUT_CYC = 50000,
  parameter int STABLE_CYC       = 256,
  parameter int LOSS_FILT_CYC    = 4,
  parameter int EN_DELAY_CYC     = 16,
  parameter int MAX_RETRY        = 3
) (
  input  logic init_clk,
  input  logic reset,
  input  logic pll_lock,
  input  logic restart,
  input  logic enable,
  input  logic kill,
  output logic pll_rst,
  output logic enclk,
  output logic lock,
  output logic fail,
  output logic drop
);

  // One timer is shared by RESET, WAIT_LOCK and EN_WAIT; they never overlap.
  localparam int TW = cnt_w(max3(RST_CYC, LOCK_TIMEOUT_CYC, EN_DELAY_CYC));
  localparam int SW = cnt_w(STABLE_CYC);
  localparam int LW = cnt_w(LOSS_FILT_CYC);
  localparam int RW = cnt_w(MAX_RETRY);

  pll_sup_state_e state;
  logic [1:0]     sync_q;
  logic           synced;
  logic [TW-1:0]  timer, timer_nxt;
  logic [SW-1:0]  stable_cnt, stable_nxt;
  logic [LW-1:0]  loss_cnt, loss_nxt;
  logic [RW-1:0]  retry, retry_nxt;
  logic           stable_hit, timeout_hit, loss_hit;

  assign synced = sync_q[1];

  // NOTE: every combinational output is given a default first, so no path
  // through the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    timer_nxt  = (timer == '1) ? timer : timer + 1'b1;
    stable_nxt = '0;
    if (synced) stable_nxt = (stable_cnt == '1) ? stable_cnt : stable_cnt + 1'b1;
    loss_nxt   = '0;
    if (!synced) loss_nxt = (loss_cnt == '1) ? loss_cnt : loss_cnt + 1'b1;
    retry_nxt  = retry + 1'b1;

    stable_hit  = (state == ST_WAIT_LOCK) && (stable_nxt == SW'(STABLE_CYC));
    timeout_hit = (state == ST_WAIT_LOCK) && (timer_nxt == TW'(LOCK_TIMEOUT_CYC));
    loss_hit    = (state == ST_RUN) && (loss_nxt == LW'(LOSS_FILT_CYC));
    drop        = ((state == ST_EN_WAIT) || (state == ST_RUN)) && (restart || loss_hit);
  end

  // NOTE: all sequential state uses non-blocking assignments, so every flop
  // in this block sees pre-edge values regardless of statement order.
  always_ff @(posedge init_clk) begin
    if (reset) begin
      // NOTE: reset is synchronous and clears the synchroniser too, so a
      // stale lock level cannot leak into the first decisions after reset.
      sync_q     <= '0;
      state      <= ST_IDLE;
      timer      <= '0;
      stable_cnt <= '0;
      loss_cnt   <= '0;
      retry      <= '0;
      pll_rst    <= 1'b1;
      enclk      <= 1'b0;
      lock       <= 1'b0;
      fail       <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], pll_lock};
      if (kill) begin
        // Upstream lost lock: hold this PLL in reset until it relocks.
        state   <= ST_IDLE;
        timer   <= '0;
        retry   <= '0;
        pll_rst <= 1'b1;
        enclk   <= 1'b0;
        lock    <= 1'b0;
        fail    <= 1'b0;
      end else if (restart) begin
        // Restart outranks timeout and loss evaluated in the same cycle.
        state   <= ST_RESET;
        timer   <= '0;
        retry   <= '0;
        pll_rst <= 1'b1;
        enclk   <= 1'b0;
        lock    <= 1'b0;
        fail    <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            pll_rst <= 1'b1;
            if (enable) begin
              state <= ST_RESET;
              timer <= '0;
            end
          end
          ST_RESET: begin
            if (timer_nxt == TW'(RST_CYC)) begin
              state      <= ST_WAIT_LOCK;
              pll_rst    <= 1'b0;
              timer      <= '0;
              stable_cnt <= '0;
            end else begin
              timer <= timer_nxt;
            end
          end
          ST_WAIT_LOCK: begin
            stable_cnt <= stable_nxt;
            timer      <= timer_nxt;
            // Stable-reach is tested first so it wins over a same-cycle timeout.
            if (stable_hit) begin
              state <= ST_EN_WAIT;
              lock  <= 1'b1;
              timer <= '0;
            end else if (timeout_hit) begin
              pll_rst <= 1'b1;
              timer   <= '0;
              if (retry_nxt == RW'(MAX_RETRY)) begin
                state <= ST_FAIL;
                fail  <= 1'b1;
              end else begin
                state <= ST_RESET;
                retry <= retry_nxt;
              end
            end
          end
          ST_EN_WAIT: begin
            if (timer_nxt == TW'(EN_DELAY_CYC)) begin
              state    <= ST_RUN;
              enclk    <= 1'b1;
              loss_cnt <= '0;
            end else begin
              timer <= timer_nxt;
            end
          end
          ST_RUN: begin
            loss_cnt <= loss_nxt;
            if (loss_hit) begin
              state <= ST_LOST;
              lock  <= 1'b0;
              enclk <= 1'b0;
            end
          end
          ST_LOST: begin
            // A loss is not a failed attempt, so the retry budget refills.
            state   <= ST_RESET;
            pll_rst <= 1'b1;
            timer   <= '0;
            retry   <= '0;
          end
          ST_FAIL: begin
            pll_rst <= 1'b1;
            fail    <= 1'b1;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor: reset/lock supervisor for up to four PLLs on init_clk.
//   init_clk, reset  supervisor clock, synchronous active-high reset
//   pll_lock         raw PLL lock outputs (asynchronous), one per channel
//   restart          single-cycle per-channel restart request
//   pll_rst, enclk   PLL reset and clock-output enable, per channel
//   lock, fail       qualified lock and retries-exhausted, per channel
//   all_lock         registered AND of lock
//   icpsel, lpfres   constant loop settings for MULTI_FAC, per channel
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int NUM_PLL          = 2,
  parameter int CASCADE          = 0,
  parameter int MULTI_FAC        = 24,
  parameter int RST_CYC          = 50,
  parameter int LOCK_TIMEOUT_CYC = 50000,
  parameter int STABLE_CYC       = 256,
  parameter int LOSS_FILT_CYC    = 4,
  parameter int EN_DELAY_CYC     = 16,
  parameter int MAX_RETRY        = 3
) (
  input  logic                 init_clk,
  input  logic                 reset,
  input  logic [NUM_PLL-1:0]   pll_lock,
  input  logic [NUM_PLL-1:0]   restart,
  output logic [NUM_PLL-1:0]   pll_rst,
  output logic [NUM_PLL-1:0]   enclk,
  output logic [NUM_PLL-1:0]   lock,
  output logic                 all_lock,
  output logic [NUM_PLL-1:0]   fail,
  output logic [6*NUM_PLL-1:0] icpsel,
  output logic [3*NUM_PLL-1:0] lpfres
);

  localparam pll_cfg_t CFG = pll_cfg_lookup(MULTI_FAC);

  if (!CFG.ok) begin : g_bad_fac
    $error("pll_lock_supervisor: unsupported MULTI_FAC %0d", MULTI_FAC);
  end
  if ((NUM_PLL < 1) || (NUM_PLL > 4)) begin : g_bad_num
    $error("pll_lock_supervisor: NUM_PLL %0d outside 1..4", NUM_PLL);
  end

  logic [NUM_PLL-1:0] drop, kill, enable;

  for (genvar i = 0; i < NUM_PLL; i++) begin : g_chan
    if ((CASCADE != 0) && (i > 0)) begin : g_casc
      // Any upstream channel leaving lock knocks out every channel after it.
      assign kill[i]   = |drop[i-1:0];
      assign enable[i] = lock[i-1] && !kill[i];
    end else begin : g_free
      assign kill[i]   = 1'b0;
      assign enable[i] = 1'b1;
    end

    pll_sup_chan #(
      .RST_CYC          (RST_CYC),
      .LOCK_TIMEOUT_CYC (LOCK_TIMEOUT_CYC),
      .STABLE_CYC       (STABLE_CYC),
      .LOSS_FILT_CYC    (LOSS_FILT_CYC),
      .EN_DELAY_CYC     (EN_DELAY_CYC),
      .MAX_RETRY        (MAX_RETRY)
    ) u_chan (
      .init_clk (init_clk),
      .reset    (reset),
      .pll_lock (pll_lock[i]),
      .restart  (restart[i]),
      .enable   (enable[i]),
      .kill     (kill[i]),
      .pll_rst  (pll_rst[i]),
      .enclk    (enclk[i]),
      .lock     (lock[i]),
      .fail     (fail[i]),
      .drop     (drop[i])
    );

    assign icpsel[6*i +: 6] = CFG.icpsel;
    assign lpfres[3*i +: 3] = CFG.lpfres;
  end

  always_ff @(posedge init_clk) begin
    if (reset) all_lock <= 1'b0;
    else       all_lock <= &lock;
  end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// tb_pll_lock_supervisor: timed-expectation scoreboard bench. Each stimulus
// step pushes the values the outputs must show at given future cycles; a
// negedge monitor pops due entries and compares them. Two instances run:
// u_dut (CASCADE=0) and u_dut_c (CASCADE=1).
module tb_pll_lock_supervisor;

  localparam int N = 2;

  // Observation selectors; +8 selects the cascade instance.
  localparam int S_RST = 0, S_LOCK = 1, S_EN = 2, S_ALL = 3, S_FAIL = 4, S_ICP = 5, S_LPF = 6;
  localparam int B = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic           rst_a, rst_b;
  logic [N-1:0]   lock_in_a, lock_in_b, restart_a, restart_b;
  logic [N-1:0]   pll_rst_a, enclk_a, lock_a, fail_a;
  logic [N-1:0]   pll_rst_b, enclk_b, lock_b, fail_b;
  logic           all_lock_a, all_lock_b;
  logic [6*N-1:0] icpsel_a, icpsel_b;
  logic [3*N-1:0] lpfres_a, lpfres_b;

  pll_lock_supervisor #(
    .NUM_PLL(N), .CASCADE(0), .MULTI_FAC(24), .RST_CYC(4), .LOCK_TIMEOUT_CYC(100),
    .STABLE_CYC(8), .LOSS_FILT_CYC(3), .EN_DELAY_CYC(2), .MAX_RETRY(2)
  ) u_dut (
    .init_clk(clk), .reset(rst_a), .pll_lock(lock_in_a), .restart(restart_a),
    .pll_rst(pll_rst_a), .enclk(enclk_a), .lock(lock_a), .all_lock(all_lock_a),
    .fail(fail_a), .icpsel(icpsel_a), .lpfres(lpfres_a)
  );

  pll_lock_supervisor #(
    .NUM_PLL(N), .CASCADE(1), .MULTI_FAC(24), .RST_CYC(4), .LOCK_TIMEOUT_CYC(100),
    .STABLE_CYC(8), .LOSS_FILT_CYC(3), .EN_DELAY_CYC(2), .MAX_RETRY(2)
  ) u_dut_c (
    .init_clk(clk), .reset(rst_b), .pll_lock(lock_in_b), .restart(restart_b),
    .pll_rst(pll_rst_b), .enclk(enclk_b), .lock(lock_b), .all_lock(all_lock_b),
    .fail(fail_b), .icpsel(icpsel_b), .lpfres(lpfres_b)
  );

  typedef struct {
    string       tag;
    int          due;
    int          sel;
    logic [15:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %h, expected %h", tag, cyc, got, exp);
    end
  endtask

  task automatic push_exp(input string tag, input int due, input int sel, input logic [15:0] val);
    exp_t e;
    e.tag = tag;
    e.due = due;
    e.sel = sel;
    e.val = val;
    sb.push_back(e);
  endtask

  function automatic logic [15:0] obs(input int sel);
    case (sel)
      S_RST:      return {14'd0, pll_rst_a};
      S_LOCK:     return {14'd0, lock_a};
      S_EN:       return {14'd0, enclk_a};
      S_ALL:      return {15'd0, all_lock_a};
      S_FAIL:     return {14'd0, fail_a};
      S_ICP:      return {4'd0, icpsel_a};
      S_LPF:      return {10'd0, lpfres_a};
      B + S_RST:  return {14'd0, pll_rst_b};
      B + S_LOCK: return {14'd0, lock_b};
      B + S_EN:   return {14'd0, enclk_b};
      B + S_ALL:  return {15'd0, all_lock_b};
      B + S_FAIL: return {14'd0, fail_b};
      default:    return 16'hDEAD;
    endcase
  endfunction

  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due <= cyc) begin
        check(sb[i].tag, obs(sb[i].sel), sb[i].val);
        sb.delete(i);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int t;
    rst_a = 1'b1;  rst_b = 1'b1;
    lock_in_a = '0; lock_in_b = '0;
    restart_a = '0; restart_b = '0;
    tick(3);

    // Reset state and constant loop settings.
    t = cyc;
    push_exp("rst_pll_rst", t + 1, S_RST,  16'b11);
    push_exp("rst_lock",    t + 1, S_LOCK, 16'b00);
    push_exp("rst_enclk",   t + 1, S_EN,   16'b00);
    push_exp("rst_fail",    t + 1, S_FAIL, 16'b00);
    push_exp("rst_all",     t + 1, S_ALL,  16'b0);
    push_exp("icpsel",      t + 1, S_ICP,  16'h071C);
    push_exp("lpfres",      t + 1, S_LPF,  16'h001B);
    push_exp("rst_c_pll",   t + 1, B + S_RST, 16'b11);
    tick(2);

    // Nominal, CASCADE=0.
    rst_a = 1'b0;
    t = cyc;
    push_exp("nom_rst_held", t + 1, S_RST, 16'b11);
    push_exp("nom_rst_end",  t + 4, S_RST, 16'b11);
    push_exp("nom_rst_low",  t + 5, S_RST, 16'b00);
    tick(20);
    lock_in_a = 2'b11;
    t = cyc;
    push_exp("nom_lock_pre", t + 9,  S_LOCK, 16'b00);
    push_exp("nom_lock",     t + 10, S_LOCK, 16'b11);
    push_exp("nom_all_pre",  t + 10, S_ALL,  16'b0);
    push_exp("nom_all",      t + 11, S_ALL,  16'b1);
    push_exp("nom_en_pre",   t + 11, S_EN,   16'b00);
    push_exp("nom_en",       t + 12, S_EN,   16'b11);
    tick(20);

    // Glitch filter: 2-cycle low is ignored.
    lock_in_a = 2'b01;
    t = cyc;
    push_exp("glitch2_lock_a", t + 4, S_LOCK, 16'b11);
    push_exp("glitch2_lock_b", t + 6, S_LOCK, 16'b11);
    push_exp("glitch2_en",     t + 6, S_EN,   16'b11);
    tick(2);
    lock_in_a = 2'b11;
    tick(13);

    // 3-cycle low: loss, reset pulse, relock.
    lock_in_a = 2'b01;
    t = cyc;
    push_exp("loss_lock_pre", t + 4,  S_LOCK, 16'b11);
    push_exp("loss_lock",     t + 5,  S_LOCK, 16'b01);
    push_exp("loss_en",       t + 5,  S_EN,   16'b01);
    push_exp("loss_all",      t + 6,  S_ALL,  16'b0);
    push_exp("loss_rst_on",   t + 6,  S_RST,  16'b10);
    push_exp("loss_rst_end",  t + 9,  S_RST,  16'b10);
    push_exp("loss_rst_off",  t + 10, S_RST,  16'b00);
    push_exp("relock_pre",    t + 17, S_LOCK, 16'b01);
    push_exp("relock",        t + 18, S_LOCK, 16'b11);
    push_exp("relock_all",    t + 19, S_ALL,  16'b1);
    push_exp("relock_en",     t + 20, S_EN,   16'b11);
    tick(3);
    lock_in_a = 2'b11;
    tick(27);

    // Restart ch1 in RUN, then interrupt its qualification once.
    lock_in_a = 2'b01;
    restart_a = 2'b10;
    t = cyc;
    push_exp("rs1_lock",    t + 1, S_LOCK, 16'b01);
    push_exp("rs1_rst_on",  t + 1, S_RST,  16'b10);
    push_exp("rs1_rst_end", t + 4, S_RST,  16'b10);
    push_exp("rs1_rst_off", t + 5, S_RST,  16'b00);
    tick(1);
    restart_a = 2'b00;
    tick(9);
    lock_in_a = 2'b11;
    t = cyc;
    push_exp("intr_no_early", t + 10, S_LOCK, 16'b01);
    push_exp("intr_pre",      t + 16, S_LOCK, 16'b01);
    push_exp("intr_lock",     t + 17, S_LOCK, 16'b11);
    tick(6);
    lock_in_a = 2'b01;
    tick(1);
    lock_in_a = 2'b11;
    tick(23);

    // Timeout/fail on ch0: restart it with its lock held low.
    lock_in_a = 2'b10;
    restart_a = 2'b01;
    t = cyc;
    push_exp("to_lock",     t + 1,   S_LOCK, 16'b10);
    push_exp("to_p1_end",   t + 4,   S_RST,  16'b01);
    push_exp("to_w1_start", t + 5,   S_RST,  16'b00);
    push_exp("to_w1_end",   t + 104, S_RST,  16'b00);
    push_exp("to_p2_start", t + 105, S_RST,  16'b01);
    push_exp("to_p2_end",   t + 108, S_RST,  16'b01);
    push_exp("to_w2_start", t + 109, S_RST,  16'b00);
    push_exp("to_w2_end",   t + 208, S_RST,  16'b00);
    push_exp("to_fail_pre", t + 208, S_FAIL, 16'b00);
    push_exp("to_fail",     t + 209, S_FAIL, 16'b01);
    push_exp("to_fail_rst", t + 209, S_RST,  16'b01);
    push_exp("fail_hold",   t + 260, S_FAIL, 16'b01);
    push_exp("fail_rst_hd", t + 260, S_RST,  16'b01);
    tick(1);
    restart_a = 2'b00;
    tick(269);
    restart_a = 2'b01;
    t = cyc;
    push_exp("rs0_fail_clr", t + 1, S_FAIL, 16'b00);
    push_exp("rs0_rst_end",  t + 4, S_RST,  16'b01);
    push_exp("rs0_rst_off",  t + 5, S_RST,  16'b00);
    tick(1);
    restart_a = 2'b00;
    tick(19);

    // Reset mid-RUN.
    t = cyc;
    push_exp("mid_en_pre",  t, S_EN, 16'b10);
    rst_a = 1'b1;
    push_exp("mid_pll_rst", t + 1, S_RST,  16'b11);
    push_exp("mid_enclk",   t + 1, S_EN,   16'b00);
    push_exp("mid_lock",    t + 1, S_LOCK, 16'b00);
    push_exp("mid_fail",    t + 1, S_FAIL, 16'b00);
    push_exp("mid_all",     t + 1, S_ALL,  16'b0);
    tick(3);

    // Cascade: ch1 waits for lock[0]; a ch0 loss drops ch1 in the same cycle.
    rst_b = 1'b0;
    t = cyc;
    push_exp("cas_rst0_off", t + 5,  B + S_RST,  16'b10);
    push_exp("cas_idle1",    t + 20, B + S_RST,  16'b10);
    push_exp("cas_lock0",    t + 20, B + S_LOCK, 16'b01);
    push_exp("cas_rst1_end", t + 24, B + S_RST,  16'b10);
    push_exp("cas_rst1_off", t + 25, B + S_RST,  16'b00);
    push_exp("cas_lock1_pr", t + 32, B + S_LOCK, 16'b01);
    push_exp("cas_lock1",    t + 33, B + S_LOCK, 16'b11);
    push_exp("cas_all",      t + 34, B + S_ALL,  16'b1);
    push_exp("cas_en",       t + 35, B + S_EN,   16'b11);
    tick(10);
    lock_in_b = 2'b11;
    tick(35);
    lock_in_b = 2'b10;
    t = cyc;
    push_exp("casl_lock_pre", t + 4, B + S_LOCK, 16'b11);
    push_exp("casl_en_pre",   t + 4, B + S_EN,   16'b11);
    push_exp("casl_lock",     t + 5, B + S_LOCK, 16'b00);
    push_exp("casl_en",       t + 5, B + S_EN,   16'b00);
    push_exp("casl_rst1",     t + 5, B + S_RST,  16'b10);
    push_exp("casl_rst_both", t + 6, B + S_RST,  16'b11);
    push_exp("casl_all",      t + 6, B + S_ALL,  16'b0);

    for (int w = 0; w < 200 && sb.size() != 0; w++) tick(1);
    check("sb_drain", 16'(sb.size()), 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
